// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - in-order instruction fetch with credit-limited requests and redirect flush
`timescale 1ns/1ps

module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  output logic [31:0] dec_pc_o,
  output logic [31:0] dec_instr_o,
  output logic        busy_o
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(QDEPTH);

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;

  // decode queue: pc/instruction pairs waiting for decode
  logic [31:0]   q_pc_q [QDEPTH];
  logic [31:0]   q_pc_d [QDEPTH];
  logic [31:0]   q_instr_q [QDEPTH];
  logic [31:0]   q_instr_d [QDEPTH];
  logic [AW-1:0] q_wr_q, q_wr_d;
  logic [AW-1:0] q_rd_q, q_rd_d;
  logic [CW-1:0] count_q, count_d;

  // pc of every accepted request, popped as its response returns (kept or dropped)
  logic [31:0]   tag_q [QDEPTH];
  logic [31:0]   tag_d [QDEPTH];
  logic [AW-1:0] tag_wr_q, tag_wr_d;
  logic [AW-1:0] tag_rd_q, tag_rd_d;

  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [31:0]   last_pc_q, last_pc_d;
  logic [31:0]   last_instr_q, last_instr_d;

  logic          redirect_act;
  logic [CW:0]   credit_sum;
  logic          req_valid;
  logic          req_fire;
  logic          rsp_fire;
  logic          rsp_keep;
  logic          dec_valid;
  logic          pop;
  logic [31:0]   redirect_target;

  always_comb begin
    redirect_act    = redirect_valid_i & (state_q != ST_BOOT);
    redirect_target = redirect_pc_i & 32'hFFFF_FFFC;
    credit_sum      = (CW+1)'(count_q) + (CW+1)'(outstanding_q);
    req_valid       = (state_q == ST_FETCH) & ~halt_i & ~redirect_valid_i & (credit_sum < DEPTH_C);
    req_fire        = req_valid & imem_req_ready_i;
    rsp_fire        = imem_rsp_valid_i & (outstanding_q != '0);
    rsp_keep        = rsp_fire & (drop_cnt_q == '0);
    dec_valid       = (count_q != '0) & ~redirect_valid_i;
    pop             = dec_valid & dec_ready_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:   state_d = ST_FETCH;
      ST_FETCH:  if (halt_i) state_d = ST_HALTED;
      ST_HALTED: if (!halt_i) state_d = ST_FETCH;
      default:   state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_act) begin
      fetch_pc_d = redirect_target;
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_comb begin
    tag_d    = tag_q;
    tag_wr_d = tag_wr_q;
    tag_rd_d = tag_rd_q;
    if (req_fire) begin
      tag_d[tag_wr_q] = fetch_pc_q;
      tag_wr_d        = tag_wr_q + AW'(1);
    end
    if (rsp_fire) begin
      tag_rd_d = tag_rd_q + AW'(1);
    end
  end

  always_comb begin
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
    drop_cnt_d    = drop_cnt_q;
    // every request still in flight after a redirect is stale, including ones already marked
    if (redirect_act) begin
      drop_cnt_d = outstanding_d;
    end else if (rsp_fire && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_comb begin
    q_pc_d       = q_pc_q;
    q_instr_d    = q_instr_q;
    q_wr_d       = q_wr_q;
    q_rd_d       = q_rd_q;
    count_d      = count_q;
    last_pc_d    = last_pc_q;
    last_instr_d = last_instr_q;
    if (redirect_act) begin
      q_wr_d  = '0;
      q_rd_d  = '0;
      count_d = '0;
    end else begin
      if (rsp_keep) begin
        q_pc_d[q_wr_q]    = tag_q[tag_rd_q];
        q_instr_d[q_wr_q] = imem_rsp_data_i;
        q_wr_d            = q_wr_q + AW'(1);
      end
      if (pop) begin
        last_pc_d    = q_pc_q[q_rd_q];
        last_instr_d = q_instr_q[q_rd_q];
        q_rd_d       = q_rd_q + AW'(1);
      end
      count_d = count_q + CW'(rsp_keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_BOOT;
      fetch_pc_q    <= RESET_PC;
      q_wr_q        <= '0;
      q_rd_q        <= '0;
      count_q       <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      last_pc_q     <= '0;
      last_instr_q  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc_q[i]    <= '0;
        q_instr_q[i] <= '0;
        tag_q[i]     <= '0;
      end
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      q_wr_q        <= q_wr_d;
      q_rd_q        <= q_rd_d;
      count_q       <= count_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      last_pc_q     <= last_pc_d;
      last_instr_q  <= last_instr_d;
      q_pc_q        <= q_pc_d;
      q_instr_q     <= q_instr_d;
      tag_q         <= tag_d;
    end
  end

  assign imem_req_valid_o = req_valid;
  assign imem_addr_o      = fetch_pc_q;
  assign dec_valid_o      = dec_valid;
  assign dec_pc_o         = (count_q != '0) ? q_pc_q[q_rd_q] : last_pc_q;
  assign dec_instr_o      = (count_q != '0) ? q_instr_q[q_rd_q] : last_instr_q;
  assign busy_o           = (outstanding_q != '0) | (drop_cnt_q != '0);

endmodule
